// File: rtl/wave_gen_pkg.sv
// Shared constants, FSM state type and LFSR helper for the DDS phase path.
package wave_gen_pkg;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;

    localparam int FREQ_W = 20;
    localparam int KS_W   = 22;
    localparam int PROD_W = FREQ_W + KS_W;
    localparam int CNT_W  = 5;

    // round(2^48 / SYS_CLK_HZ); tuning word = (freq * K_SCALE) >> 16
    localparam logic [PROD_W-1:0] K_SCALE   = PROD_W'(2814750);
    localparam logic [31:0]       PULSE_INC = 32'd128849019;
    localparam logic [31:0]       RST_INC   = 32'd4294967;
    localparam logic [FREQ_W-1:0] RST_FREQ  = FREQ_W'(100000);

    // Fibonacci LFSR, taps 16,14,13,11
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/freq_tw_mult.sv
// Sequential shift-add multiplier: freq * K_SCALE, one multiplier bit per cycle, LSB first.
module freq_tw_mult
    import wave_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] freq,
    output logic              done,
    output logic [31:0]       tw
);

    logic [FREQ_W-1:0] mplier;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] product;
    logic              running;

    // NOTE: all state here is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                running <= 1'b0;
            end else if (start) begin
                mplier  <= freq;
                cnt     <= '0;
                product <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0])
                    product <= product + (K_SCALE << cnt);
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CNT_W'(FREQ_W - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    // Floor of the >>16, zero-extended to the 32-bit tuning word.
    assign tw = 32'(product[PROD_W-1:16]);

endmodule

// File: rtl/dds_phase_accum.sv
// Frequency-to-tuning-word conversion, pulse-mode bypass and 32-bit phase accumulator.
// Optional phase dither is enabled by defining PHASE_DITHER_EN.
module dds_phase_accum
    import wave_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] freq_in,
    input  logic              pulse_mode,
    input  logic              acc_en,
    input  logic              phase_clr,
    output logic [31:0]       phase_inc,
    output logic              inc_update,
    output logic              busy,
    output logic [11:0]       phase_out
);

    state_t            state, state_nx;
    logic [FREQ_W-1:0] freq_lat;
    logic              lat_valid;
    logic              start;
    logic              mul_done;
    logic [31:0]       mul_tw;
    logic [31:0]       phase_acc;
    logic [11:0]       phase_top;

    freq_tw_mult u_mult (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (pulse_mode),
        .freq  (freq_in),
        .done  (mul_done),
        .tw    (mul_tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        if (pulse_mode) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (!lat_valid || freq_in != freq_lat) begin
                    state_nx = MUL;
                    start    = 1'b1;
                end
                MUL:     if (mul_done) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == MUL);
    end

    // Holding pulse_mode drops lat_valid, which forces a reconversion once it is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_lat   <= RST_FREQ;
            lat_valid  <= 1'b1;
            phase_inc  <= RST_INC;
            inc_update <= 1'b0;
        end else begin
            inc_update <= 1'b0;
            if (pulse_mode) begin
                lat_valid  <= 1'b0;
                phase_inc  <= PULSE_INC;
                inc_update <= (phase_inc != PULSE_INC);
            end else begin
                if (start) begin
                    freq_lat  <= freq_in;
                    lat_valid <= 1'b1;
                end
                if (state == DONE) begin
                    phase_inc  <= mul_tw;
                    inc_update <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         phase_acc <= '0;
        else if (phase_clr) phase_acc <= '0;
        else if (acc_en)    phase_acc <= phase_acc + phase_inc;
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] lfsr;
    logic [31:0] dith_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lfsr <= LFSR_SEED;
        else if (phase_clr) lfsr <= LFSR_SEED;
        else if (acc_en)    lfsr <= lfsr_next(lfsr);
    end

    assign dith_sum  = phase_acc + {12'b0, lfsr, 4'b0};
    assign phase_top = dith_sum[31:20];
`else
    assign phase_top = phase_acc[31:20];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_out <= '0;
        else        phase_out <= phase_top;
    end

endmodule
